// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver:
// frame state encoding, data width, default bit period and frame length.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 217;   // 25 MHz / 115200 baud

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Clock cycles occupied by one frame: start + data + optional parity + stop.
    function automatic int uart_frame_cycles(input int clks_per_bit, input bit parity_en);
        return (UART_DATA_BITS + 2 + (parity_en ? 1 : 0)) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-stream handshake and serial-line status between a producer and uart_tx.
interface uart_tx_if;
    import uart_pkg::*;

    logic                      i_tx_dv;
    logic [UART_DATA_BITS-1:0] i_tx_byte;
    logic                      o_tx_ready;
    logic                      o_tx_serial;
    logic                      o_tx_active;
    logic                      o_tx_done;

    modport master (
        output i_tx_dv, i_tx_byte,
        input  o_tx_ready, o_tx_serial, o_tx_active, o_tx_done
    );

    modport slave (
        input  i_tx_dv, i_tx_byte,
        output o_tx_ready, o_tx_serial, o_tx_active, o_tx_done
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit. Holding i_restart keeps the count at zero so a new bit period
// starts cleanly on the cycle after i_restart drops.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic i_clock,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wrap at the end of each bit period, or hold at zero while restarting.
    always_comb begin
        if (i_restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default. A one-entry holding register lets the
// producer queue the next byte during a frame so frames go out back-to-back.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data
// bits and the stop bit (8E1).
// All line outputs are registered from the current state, so the line lags
// the state machine by one cycle; a byte accepted at edge N shows its start
// bit from edge N+1.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic     i_clock,
    input  logic     i_rst_n,
    uart_tx_if.slave tx
);

    uart_state_e               state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] hold_q, hold_d;
    logic                      hold_valid_q, hold_valid_d;
    logic                      frame_end_q, frame_end_d;
    logic                      serial_q, serial_d;
    logic                      active_q, active_d;
    logic                      done_q, done_d;

    logic tick;
    logic accept;
    logic byte_avail;
    logic shifter_free;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .i_clock   (i_clock),
        .i_rst_n   (i_rst_n),
        .i_restart (state_q == IDLE),
        .o_tick    (tick)
    );

    assign accept       = tx.i_tx_dv && !hold_valid_q;
    assign byte_avail   = accept || hold_valid_q;
    assign shifter_free = (state_q == IDLE) || ((state_q == STOP) && tick);

    // State register plus datapath and registered line outputs.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            frame_end_q  <= 1'b0;
            serial_q     <= 1'b1;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            frame_end_q  <= frame_end_d;
            serial_q     <= serial_d;
            active_q     <= active_d;
            done_q       <= done_d;
        end
    end

    // Next state, bit index and routing of accepted bytes into shifter or hold.
    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        frame_end_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (byte_avail) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    frame_end_d = 1'b1;
                    state_d     = byte_avail ? START : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A held byte always wins the freed shifter; a new byte only goes
        // straight in when nothing is waiting ahead of it.
        if (shifter_free) begin
            if (hold_valid_q) begin
                shift_d      = hold_q;
                hold_valid_d = 1'b0;
            end else if (accept) begin
                shift_d = tx.i_tx_byte;
            end
        end else if (accept) begin
            hold_d       = tx.i_tx_byte;
            hold_valid_d = 1'b1;
        end
    end

    // Line level, activity and done pulse derived from the current state.
    always_comb begin
        serial_d = 1'b1;
        case (state_q)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_q[bit_idx_q];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_d = ^shift_q;
`endif
            default: serial_d = 1'b1;
        endcase
        active_d = (state_q != IDLE);
        done_d   = frame_end_q;
    end

    assign tx.o_tx_ready  = ~hold_valid_q;
    assign tx.o_tx_serial = serial_q;
    assign tx.o_tx_active = active_q;
    assign tx.o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx with CLKS_PER_BIT=4: directed scenarios with literal
// expectations plus a randomized byte stream, all checked every cycle against
// a frame-timeline model of the line.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    uart_tx_if txif ();

    uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_clock (clk),
        .i_rst_n (rst_n),
        .tx      (txif)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Level of line bit k of a frame carrying byte b.
    function automatic logic line_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[3'(k - 1)];
        if (NBITS == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    // ---------------- reference model ----------------
    // Frame timeline: a frame lasts FRAME cycles from acceptance; the line
    // shows that timeline delayed by one cycle.
    bit         m_busy   = 1'b0;
    bit         m_hold_v = 1'b0;
    bit         m_end    = 1'b0;
    int         m_cyc    = 0;
    logic [7:0] m_byte   = '0;
    logic [7:0] m_hold   = '0;
    logic       exp_serial = 1'b1;
    logic       exp_active = 1'b0;
    logic       exp_done   = 1'b0;
    logic       exp_ready  = 1'b1;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 1'b0; m_hold_v = 1'b0; m_end = 1'b0; m_cyc = 0;
                exp_serial = 1'b1; exp_active = 1'b0; exp_done = 1'b0; exp_ready = 1'b1;
            end else begin
                bit acc;
                exp_serial = m_busy ? line_bit(m_byte, m_cyc / CPB) : 1'b1;
                exp_active = m_busy;
                exp_done   = m_end;
                m_end      = 1'b0;
                acc = txif.i_tx_dv && !m_hold_v;
                if (m_busy) begin
                    m_cyc++;
                    if (m_cyc == FRAME) begin
                        m_busy = 1'b0;
                        m_end  = 1'b1;
                    end
                end
                if (!m_busy) begin
                    if (m_hold_v) begin
                        m_busy = 1'b1; m_cyc = 0; m_byte = m_hold; m_hold_v = 1'b0;
                    end else if (acc) begin
                        m_busy = 1'b1; m_cyc = 0; m_byte = txif.i_tx_byte;
                    end
                end else if (acc) begin
                    m_hold = txif.i_tx_byte; m_hold_v = 1'b1;
                end
                exp_ready = !m_hold_v;
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_serial", 32'(txif.o_tx_serial), 32'(exp_serial));
            chk("cyc_active", 32'(txif.o_tx_active), 32'(exp_active));
            chk("cyc_done",   32'(txif.o_tx_done),   32'(exp_done));
            chk("cyc_ready",  32'(txif.o_tx_ready),  32'(exp_ready));
        end
    end

    // Activity statistics: total active cycles, done pulses, last active run.
    int act_total  = 0;
    int done_total = 0;
    int run        = 0;
    int last_run   = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (txif.o_tx_active) begin
                act_total++;
                run++;
            end else if (run != 0) begin
                last_run = run;
                run      = 0;
            end
            if (txif.o_tx_done) done_total++;
        end
    end

    // ---------------- stimulus ----------------
    // Called right after a negedge; the byte is sampled on the next posedge.
    task automatic send(input logic [7:0] b);
        txif.i_tx_dv   = 1'b1;
        txif.i_tx_byte = b;
        @(negedge clk);
        txif.i_tx_dv   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_busy || m_hold_v || txif.o_tx_active || !txif.o_tx_ready) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_in_budget", 32'(n < budget), 32'd1);
        repeat (3) @(negedge clk);
    endtask

`ifdef UART_TX_PARITY_EN
    bit pat_a5 [NBITS] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    bit pat_a5 [NBITS] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

    initial begin
        int d0;
        int a0;
        txif.i_tx_dv   = 1'b0;
        txif.i_tx_byte = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_serial", 32'(txif.o_tx_serial), 32'd1);
        chk("reset_active", 32'(txif.o_tx_active), 32'd0);
        chk("reset_done",   32'(txif.o_tx_done),   32'd0);
        chk("reset_ready",  32'(txif.o_tx_ready),  32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte 0xA5: bit pattern, one-edge latency, done timing.
        d0 = done_total;
        send(8'hA5);
        chk("a5_latency_serial", 32'(txif.o_tx_serial), 32'd1);
        chk("a5_latency_active", 32'(txif.o_tx_active), 32'd0);
        repeat (2) @(negedge clk);
        for (int k = 0; k < NBITS; k++) begin
            chk($sformatf("a5_bit%0d", k), 32'(txif.o_tx_serial), 32'(pat_a5[k]));
            if (k < NBITS - 1) repeat (CPB) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("a5_done_not_yet", 32'(txif.o_tx_done),   32'd0);
        chk("a5_active_last",  32'(txif.o_tx_active), 32'd1);
        @(negedge clk);
        chk("a5_done_pulse",   32'(txif.o_tx_done),   32'd1);
        chk("a5_active_off",   32'(txif.o_tx_active), 32'd0);
        wait_idle(200);
        chk("a5_done_count", 32'(done_total - d0), 32'd1);

        // Back-to-back: second byte queued mid-frame.
        d0 = done_total;
        send(8'h55);
        repeat (10) @(negedge clk);
        chk("b2b_ready_before", 32'(txif.o_tx_ready), 32'd1);
        send(8'h0F);
        chk("b2b_ready_drops", 32'(txif.o_tx_ready), 32'd0);
        wait_idle(400);
        chk("b2b_active_run", 32'(last_run), 32'(2 * FRAME));
        chk("b2b_done_count", 32'(done_total - d0), 32'd2);

        // Overflow: three consecutive bytes, third dropped.
        d0 = done_total;
        a0 = act_total;
        txif.i_tx_dv = 1'b1; txif.i_tx_byte = 8'h01;
        @(negedge clk);
        chk("ovf_ready_2nd", 32'(txif.o_tx_ready), 32'd1);
        txif.i_tx_byte = 8'h02;
        @(negedge clk);
        chk("ovf_ready_3rd", 32'(txif.o_tx_ready), 32'd0);
        txif.i_tx_byte = 8'h03;
        @(negedge clk);
        txif.i_tx_dv = 1'b0;
        wait_idle(400);
        chk("ovf_done_count",    32'(done_total - d0), 32'd2);
        chk("ovf_active_cycles", 32'(act_total - a0),  32'(2 * FRAME));

        // Simultaneous: byte presented on the final stop cycle of the frame state.
        d0 = done_total;
        send(8'h11);
        repeat (FRAME - 1) @(negedge clk);
        chk("sim_ready", 32'(txif.o_tx_ready), 32'd1);
        send(8'h3C);
        wait_idle(400);
        chk("sim_active_run", 32'(last_run), 32'(2 * FRAME));
        chk("sim_done_count", 32'(done_total - d0), 32'd2);

        // Reset during data bit 3 with a byte also held.
        send(8'h5A);
        send(8'hC3);
        repeat (17) @(negedge clk);
        d0 = done_total;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_serial", 32'(txif.o_tx_serial), 32'd1);
        chk("rst_active", 32'(txif.o_tx_active), 32'd0);
        chk("rst_ready",  32'(txif.o_tx_ready),  32'd1);
        chk("rst_done",   32'(txif.o_tx_done),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (FRAME + 5) @(negedge clk);
        chk("rst_no_done", 32'(done_total - d0), 32'd0);
        d0 = done_total;
        send(8'($urandom));
        wait_idle(200);
        chk("rst_after_done", 32'(done_total - d0), 32'd1);

`ifdef UART_TX_PARITY_EN
        // Parity bit values and 11-bit frame length.
        send(8'h07);
        repeat (CPB * 9 + 2) @(negedge clk);
        chk("par_07_bit", 32'(txif.o_tx_serial), 32'd1);
        wait_idle(200);
        chk("par_07_frame", 32'(last_run), 32'd44);
        send(8'h03);
        repeat (CPB * 9 + 2) @(negedge clk);
        chk("par_03_bit", 32'(txif.o_tx_serial), 32'd0);
        wait_idle(200);
`endif

        // Randomized stream: bursts, drops and back-to-back boundaries.
        repeat (3000) begin
            @(negedge clk);
            txif.i_tx_dv   = ($urandom_range(0, 7) == 0);
            txif.i_tx_byte = 8'($urandom);
        end
        @(negedge clk);
        txif.i_tx_dv = 1'b0;
        wait_idle(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the serial-output counterpart of uart_rx.
- Takes parallel bytes with a valid/ready handshake and drives an 8N1 frame on the TX pin.
- At top level it echoes uart_rx bytes back to the host or carries display/status data out.
- One-entry holding register, so a producer can queue the next byte during a frame and frames go out back-to-back.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per bit (25 MHz / 115200 baud); legal range >= 2.

Ports:
- i_clock  in  1  system clock; all logic rises on this edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tx_dv  in  1  byte valid; accepted on a rising edge where i_tx_dv && o_tx_ready.
- i_tx_byte  in  8  byte to send; sampled only on acceptance.
- o_tx_ready  out  1  holding register empty; combinational ~hold_valid.
- o_tx_serial  out  1  serial line; idle high; registered.
- o_tx_active  out  1  high for every cycle a frame is on the line; registered.
- o_tx_done  out  1  one-cycle pulse after each frame's stop bit completes; registered.

Behaviour:
- Reset (async assert, sync release): o_tx_serial=1, o_tx_active=0, o_tx_done=0, hold_valid=0 (so o_tx_ready=1), state=IDLE, counters=0.
- States: IDLE, START, DATA, STOP.
  - IDLE -> START when a byte is available: accepted this cycle, or hold_valid.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START if a byte is available, else IDLE.
- Acceptance routing:
  - Shifter free (IDLE, or the last STOP cycle) and hold empty: byte loads the shifter directly.
  - Otherwise: byte loads the holding register.
  - When the shifter frees and hold_valid=1: hold moves to the shifter and hold_valid clears.
- Latency: byte accepted at edge N, idle line -> o_tx_serial=0 and o_tx_active=1 from edge N+1.
- Bit timing:
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - Data goes LSB first.
  - One stop bit, high.
  - Frame = 10*CLKS_PER_BIT cycles.
- Back-to-back: the next start bit follows the last stop-bit cycle with zero idle cycles. o_tx_active stays high across the boundary.
- o_tx_done pulses on the cycle after each stop bit ends, including the back-to-back case (concurrent with the next start bit).
- Full: i_tx_dv while o_tx_ready=0 is ignored. The byte is dropped; no state change.
- Simultaneous: the last STOP cycle with hold empty and i_tx_dv=1 -> byte accepted, START next cycle, no gap.
- Reset mid-frame: line returns high immediately; the in-flight byte and held byte are discarded; no o_tx_done.
- Widths: bit counter $clog2(CLKS_PER_BIT) bits, counting 0..CLKS_PER_BIT-1. Data index 3 bits.
- No combinational path from i_tx_byte to any output.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It sends the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11*CLKS_PER_BIT cycles; o_tx_done is delayed accordingly.
- Undefined: 8N1 exactly as above; the PARITY state and its logic are absent.

Decomposition:
- Shared uart_pkg, also to be used by uart_rx:
  - state enum: IDLE, START, DATA, PARITY, STOP
  - localparam UART_DATA_BITS=8
  - default CLKS_PER_BIT=217
  - function computing frame length with/without parity
- One natural sub-module: uart_baud_tick. Counter with i_clock, i_rst_n, i_restart; emits o_tick on count CLKS_PER_BIT-1. Reusable by uart_rx.

Test Plan (CLKS_PER_BIT=4):
- Single byte: i_tx_dv pulse with 0xA5 from idle -> serial 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. Start bit begins one edge after acceptance. o_tx_done pulses once, 40 cycles after start.
- Back-to-back: 0x55 accepted, then 0x0F presented while o_tx_ready=1 mid-frame. o_tx_ready drops until the first frame ends. Second start bit is immediately after the first stop bit: 80 contiguous active cycles, two o_tx_done pulses.
- Overflow: three bytes 0x01, 0x02, 0x03 presented on consecutive cycles from idle. 0x01 and 0x02 are sent; 0x03 is dropped (o_tx_ready=0 when presented). Exactly two frames go out.
- Simultaneous: 0x3C presented exactly on the last stop-bit cycle of a prior frame with hold empty. It is accepted, its start bit begins the next cycle, zero idle gap.
- Reset mid-frame: i_rst_n low during DATA bit 3 -> o_tx_serial=1, o_tx_active=0, o_tx_ready=1 without waiting for a clock. No done pulse; a later byte transmits correctly.
- Parity build (UART_TX_PARITY_EN): 0x07 -> parity bit 1 after data, frame 44 cycles. 0x03 -> parity bit 0.
